// File: rtl/fwd_source_ctrl_pkg.sv
// Shared types for the operand-forwarding producer block.
// Holds the FSM state encoding, the per-stage metadata record and the $0 constant.
package fwd_source_ctrl_pkg;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } fsm_state_t;

    // Address width used inside the stage record; the top-level REG_AW must match it.
    localparam int unsigned REC_AW = 5;

    localparam logic [REC_AW-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [REC_AW-1:0] rw;
        logic              we;
        logic              load;
        logic              halt;
    } stage_rec_t;

    // A write to $0 is architecturally discarded, so it must never be offered for forwarding.
    function automatic stage_rec_t sanitize_rec(input stage_rec_t rec);
        stage_rec_t r;
        r = rec;
        if (rec.rw == REG_ZERO) begin
            r.we = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/fwd_source_ctrl_stage_rec_reg.sv
// One pipeline-stage metadata register: async reset, loads either the incoming
// record (with $0 write suppression) or an all-zero bubble every cycle.
module stage_rec_reg
    import fwd_source_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_bubble,
    input  stage_rec_t i_d,
    output stage_rec_t o_q
);

    stage_rec_t r_rec;

    // Advance the record on every edge; a bubble clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rec <= '0;
        end else if (i_bubble) begin
            r_rec <= '0;
        end else begin
            r_rec <= sanitize_rec(i_d);
        end
    end

    assign o_q = r_rec;

endmodule

// File: rtl/fwd_source_ctrl.sv
// Producer side of operand forwarding: tracks rw/we metadata through EX/MEM/WB,
// drives the stage-4/stage-5 forwarding pairs, detects load-use hazards and
// controls IF/ID stall, EX bubble and halt.
// Optional stall-cycle counter enabled by defining STALL_CNT_EN.
module fwd_source_ctrl
    import fwd_source_ctrl_pkg::*;
#(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned RW_W   = 32,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic [REG_AW-1:0] id_rw,
    input  logic              id_we,
    input  logic              id_load,
    input  logic              id_halt,
    input  logic              id_flush,
    input  logic              resume,
    output logic              stall_if,
    output logic              stall_id,
    output logic              bubble_ex,
    output logic [RW_W-1:0]   rw4,
    output logic              we4,
    output logic [RW_W-1:0]   rw5,
    output logic              we5,
    output logic              halted,
    output logic [CNT_W-1:0]  stall_cnt
);

    fsm_state_t r_state;
    stage_rec_t w_id_rec;
    stage_rec_t w_ex_q;
    stage_rec_t w_mem_q;
    stage_rec_t w_wb_q;
    logic       w_load_use;
    logic       w_stall;

    // An invalid ID slot enters EX as a bubble.
    always_comb begin
        w_id_rec = '0;
        if (id_valid) begin
            w_id_rec.rw   = id_rw;
            w_id_rec.we   = id_we;
            w_id_rec.load = id_load;
            w_id_rec.halt = id_halt;
        end
    end

    // Only a load sitting in EX needs a stall; once in MEM its data is forwardable.
    assign w_load_use = id_valid & ~id_flush & w_ex_q.load & w_ex_q.we &
                        ((id_use_rs & (id_rs == w_ex_q.rw)) |
                         (id_use_rt & (id_rt == w_ex_q.rw)));

    assign w_stall   = ~rst & (w_load_use | (r_state == ST_HALT));
    assign stall_if  = w_stall;
    assign stall_id  = w_stall;
    assign bubble_ex = ~rst & (w_stall | id_flush);

    stage_rec_reg u_ex (
        .clk      (clk),
        .rst      (rst),
        .i_bubble (bubble_ex),
        .i_d      (w_id_rec),
        .o_q      (w_ex_q)
    );

    stage_rec_reg u_mem (
        .clk      (clk),
        .rst      (rst),
        .i_bubble (1'b0),
        .i_d      (w_ex_q),
        .o_q      (w_mem_q)
    );

    stage_rec_reg u_wb (
        .clk      (clk),
        .rst      (rst),
        .i_bubble (1'b0),
        .i_d      (w_mem_q),
        .o_q      (w_wb_q)
    );

    assign rw4 = RW_W'(w_mem_q.rw);
    assign we4 = w_mem_q.we;
    assign rw5 = RW_W'(w_wb_q.rw);
    assign we5 = w_wb_q.we;

    // RUN/HALT sequencing: enter on a halt in EX, leave on a resume pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            case (r_state)
                ST_RUN:  if (w_ex_q.halt) r_state <= ST_HALT;
                ST_HALT: if (resume)      r_state <= ST_RUN;
                default: r_state <= ST_RUN;
            endcase
        end
    end

    assign halted = (r_state == ST_HALT);

`ifdef STALL_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;

    // Count every edge on which the front end is held (load-use or HALT).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (stall_if) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign stall_cnt = r_stall_cnt;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fwd_source_ctrl.sv
// Directed self-checking bench for fwd_source_ctrl.
module tb_fwd_source_ctrl;

    localparam int unsigned REG_AW = 5;
    localparam int unsigned RW_W   = 32;
    localparam int unsigned CNT_W  = 32;

`ifdef STALL_CNT_EN
    localparam logic [31:0] EXP_CNT = 32'd5;
`else
    localparam logic [31:0] EXP_CNT = 32'd0;
`endif

    logic              clk;
    logic              rst;
    logic              id_valid;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic              id_use_rs;
    logic              id_use_rt;
    logic [REG_AW-1:0] id_rw;
    logic              id_we;
    logic              id_load;
    logic              id_halt;
    logic              id_flush;
    logic              resume;
    logic              stall_if;
    logic              stall_id;
    logic              bubble_ex;
    logic [RW_W-1:0]   rw4;
    logic              we4;
    logic [RW_W-1:0]   rw5;
    logic              we5;
    logic              halted;
    logic [CNT_W-1:0]  stall_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    fwd_source_ctrl #(
        .REG_AW (REG_AW),
        .RW_W   (RW_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .id_valid  (id_valid),
        .id_rs     (id_rs),
        .id_rt     (id_rt),
        .id_use_rs (id_use_rs),
        .id_use_rt (id_use_rt),
        .id_rw     (id_rw),
        .id_we     (id_we),
        .id_load   (id_load),
        .id_halt   (id_halt),
        .id_flush  (id_flush),
        .resume    (resume),
        .stall_if  (stall_if),
        .stall_id  (stall_id),
        .bubble_ex (bubble_ex),
        .rw4       (rw4),
        .we4       (we4),
        .rw5       (rw5),
        .we5       (we5),
        .halted    (halted),
        .stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic urs, input logic urt, input logic [4:0] rw,
                         input logic we, input logic ld, input logic hlt, input logic fl);
        id_valid  = v;
        id_rs     = rs;
        id_rt     = rt;
        id_use_rs = urs;
        id_use_rt = urt;
        id_rw     = rw;
        id_we     = we;
        id_load   = ld;
        id_halt   = hlt;
        id_flush  = fl;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst    = 1'b1;
        resume = 1'b0;
        idle();
        id_flush = 1'b1;
        #2;
        chk("reset_rw4", rw4, 32'd0);
        chk("reset_we4", {31'd0, we4}, 32'd0);
        chk("reset_halted", {31'd0, halted}, 32'd0);
        chk("reset_bubble_gated", {31'd0, bubble_ex}, 32'd0);
        tick();
        chk("reset_stall_if", {31'd0, stall_if}, 32'd0);
        chk("reset_cnt", stall_cnt, 32'd0);
        rst = 1'b0;
        idle();

        // Write to $7 reaches MEM, then async reset mid-stream
        drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        idle();
        tick();
        settle();
        chk("mem7_rw4", rw4, 32'd7);
        chk("mem7_we4", {31'd0, we4}, 32'd1);
        rst = 1'b1;
        #1;
        chk("async_rst_rw4", rw4, 32'd0);
        chk("async_rst_we4", {31'd0, we4}, 32'd0);
        chk("async_rst_halted", {31'd0, halted}, 32'd0);
        rst = 1'b0;
        #1;

        // $0 write suppression
        drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        idle();
        tick();
        settle();
        chk("zero_rw4", rw4, 32'd0);
        chk("zero_we4", {31'd0, we4}, 32'd0);

        // Load-use on rs
        drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 5'd8, 5'd0, 1'b1, 1'b0, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0);
        settle();
        chk("lu_stall_if", {31'd0, stall_if}, 32'd1);
        chk("lu_stall_id", {31'd0, stall_id}, 32'd1);
        chk("lu_bubble", {31'd0, bubble_ex}, 32'd1);
        tick();
        settle();
        chk("lu_no_second_stall", {31'd0, stall_if}, 32'd0);
        chk("lu_no_second_bubble", {31'd0, bubble_ex}, 32'd0);
        chk("lu_rw4", rw4, 32'd8);
        chk("lu_we4", {31'd0, we4}, 32'd1);
        tick();
        idle();
        settle();
        chk("lu_rw5", rw5, 32'd8);
        chk("lu_we5", {31'd0, we5}, 32'd1);
        chk("lu_mem_bubble", rw4, 32'd0);
        tick();
        settle();
        chk("add_rw4", rw4, 32'd10);
        chk("add_we4", {31'd0, we4}, 32'd1);

        // No false stalls; rt hazard
        drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 5'd9, 5'd9, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        settle();
        chk("nofalse_r9", {31'd0, stall_if}, 32'd0);
        drive(1'b1, 5'd8, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        settle();
        chk("nofalse_unused_rs", {31'd0, stall_if}, 32'd0);
        drive(1'b1, 5'd0, 5'd8, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        settle();
        chk("rt_hazard_stall_id", {31'd0, stall_id}, 32'd1);
        drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        settle();
        chk("nofalse_load0", {31'd0, stall_if}, 32'd0);
        chk("nofalse_load0_bub", {31'd0, bubble_ex}, 32'd0);

        // Flush beats hazard
        drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 5'd8, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b1);
        settle();
        chk("flush_bubble", {31'd0, bubble_ex}, 32'd1);
        chk("flush_stall_if", {31'd0, stall_if}, 32'd0);
        chk("flush_stall_id", {31'd0, stall_id}, 32'd0);
        tick();
        idle();
        tick();
        settle();
        chk("flush_killed_rw4", rw4, 32'd0);
        chk("flush_killed_we4", {31'd0, we4}, 32'd0);

        // Load-use then halt
        rst = 1'b1;
        #1;
        rst = 1'b0;
        #1;
        chk("rst2_cnt", stall_cnt, 32'd0);
        drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 5'd8, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        settle();
        chk("halt_lu_stall", {31'd0, stall_if}, 32'd1);
        chk("halt_lu_halted", {31'd0, halted}, 32'd0);
        tick();
        settle();
        chk("halt_wait_stall", {31'd0, stall_if}, 32'd0);
        chk("halt_wait_halted", {31'd0, halted}, 32'd0);
        tick();
        idle();
        settle();
        chk("halt_in_ex_halted", {31'd0, halted}, 32'd0);
        tick();
        settle();
        chk("halted_1", {31'd0, halted}, 32'd1);
        chk("halted_stall_if", {31'd0, stall_if}, 32'd1);
        chk("halted_stall_id", {31'd0, stall_id}, 32'd1);
        chk("halted_bubble", {31'd0, bubble_ex}, 32'd1);
        tick();
        tick();
        tick();
        settle();
        chk("halted_hold", {31'd0, halted}, 32'd1);
        resume = 1'b1;
        settle();
        chk("halted_before_resume_edge", {31'd0, halted}, 32'd1);
        tick();
        resume = 1'b0;
        settle();
        chk("resumed_halted", {31'd0, halted}, 32'd0);
        chk("resumed_stall_if", {31'd0, stall_if}, 32'd0);
        chk("stall_cnt", stall_cnt, EXP_CNT);
        resume = 1'b1;
        tick();
        resume = 1'b0;
        settle();
        chk("resume_in_run", {31'd0, halted}, 32'd0);
        chk("resume_in_run_stall", {31'd0, stall_if}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fwd_source_ctrl.md
Name: fwd_source_ctrl

Overview:
- Producer side of the operand-forwarding interface in the 5-stage pipeline.
- Carries destination-register and write-enable metadata of in-flight instructions through EX, MEM and WB.
- Drives the stage-4/stage-5 rw/we pairs consumed by the per-operand forwarding muxes.
- Detects the load-use hazard that forwarding cannot cover, and generates IF/ID stall, EX bubble and halt control.

Parameters:
- REG_AW, 5, register address width.
- RW_W, 32, width of rw4/rw5 outputs; upper bits are zero-filled.
- CNT_W, 32, width of the stall counter (optional feature).

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  asynchronous, active-high reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs  in  REG_AW  source register 1 of the ID instruction.
- id_rt  in  REG_AW  source register 2 of the ID instruction.
- id_use_rs  in  1  ID instruction reads rs.
- id_use_rt  in  1  ID instruction reads rt.
- id_rw  in  REG_AW  destination register of the ID instruction.
- id_we  in  1  ID instruction writes the register file.
- id_load  in  1  ID instruction is a load.
- id_halt  in  1  ID instruction is a halting syscall.
- id_flush  in  1  kill the ID instruction (taken branch resolved).
- resume  in  1  one-cycle pulse that leaves HALT.
- stall_if  out  1  hold PC.
- stall_id  out  1  hold the IF/ID register.
- bubble_ex  out  1  insert a NOP into ID/EX.
- rw4  out  RW_W  MEM-stage destination register.
- we4  out  1  MEM-stage write enable.
- rw5  out  RW_W  WB-stage destination register.
- we5  out  1  WB-stage write enable.
- halted  out  1  FSM is in HALT.
- stall_cnt  out  CNT_W  stall-cycle count (STALL_CNT_EN only).

Behaviour:
- Internal stage records EX, MEM, WB, each holding {rw, we, load, halt}.
- On every clk edge: EX→MEM, MEM→WB.
- EX is loaded from ID, or with a bubble (all zero) when bubble_ex=1.
- we stored into a record is forced to 0 when rw==0, so $0 is never forwarded.
- rw4/we4 come from the MEM record; rw5/we5 from the WB record. All are registered, zero-extended, and carry no combinational input path.
- Load-use hazard (combinational): id_valid & !id_flush & EX.load & EX.we & ((id_use_rs & id_rs==EX.rw) | (id_use_rt & id_rt==EX.rw)).
- Hazard response: stall_if=stall_id=bubble_ex=1 for exactly one cycle. Next cycle the load is in MEM, where read data is forwardable, so no second stall occurs.
- A load in MEM never stalls, because data memory reads asynchronously.
- id_flush=1: bubble_ex=1, no stall; flush takes priority over the hazard.
- FSM states RUN, HALT:
  - RUN→HALT on the edge where an instruction with halt=1 is in EX. It still propagates to MEM/WB.
  - In HALT: stall_if=stall_id=bubble_ex=1 every cycle and halted=1. MEM/WB keep draining into bubbles.
  - HALT→RUN on the edge where resume=1; halted drops the following cycle.
  - resume in RUN is ignored.
- Halt and load-use together in the same cycle: the load-use stall is applied first and the halt instruction waits in ID.
- Reset, whether asserted at startup or mid-operation, clears all records and the counter and sets the FSM to RUN. Outputs under reset: rw4=rw5=0, we4=we5=0, stall_if=stall_id=bubble_ex=0, halted=0.

Optional Feature:
- STALL_CNT_EN defined: stall_cnt increments by 1 on each clk edge where stall_if=1 (load-use or HALT). It wraps at 2^CNT_W and resets to 0.
- Undefined: stall_cnt is tied to 0 and the counter register is not built.

Decomposition:
- Shared package holds:
  - FSM state encoding (ST_RUN=0, ST_HALT=1).
  - The stage-record struct {rw, we, load, halt}.
  - The REG_ZERO constant.
- One sub-module, stage_rec_reg: a single stage record register with async reset and bubble/load select, instantiated three times.

Test Plan:
- Reset: assert rst mid-stream with MEM rw=7, we=1 → rw4=0 and we4=0 immediately (async), halted=0.
- Load-use: load $8 enters EX; ID add reads rs=$8 → stall_if=stall_id=bubble_ex=1 for exactly one cycle. Next cycle rw4=8, we4=1 and there is no stall.
- No false stall: load $8 in EX, ID reads $9; also load $0 in EX with ID reading $0 → no stall in either case.
- $0 suppression: ID writes rw=0 with we=1 → two cycles later rw4=0, we4=0.
- Flush priority: hazard present together with id_flush=1 → bubble_ex=1, stall_if=0.
- Halt: halt instruction reaches EX → halted=1 and stalls asserted until a resume pulse. With STALL_CNT_EN, 4 HALT cycles plus 1 load-use stall give stall_cnt=5.
